// File: rtl/fp_pkg.sv
// Shared types and field constants for the packed {sign, exponent, mantissa} floating-point
// format used by fp_adder and its downstream converters.
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SHIFT = 3'd2,
        SIGN  = 3'd3,
        DONE  = 3'd4
    } fti_state_t;

    typedef enum logic [2:0] {
        FP_ZERO   = 3'd0,
        FP_DENORM = 3'd1,
        FP_NORMAL = 3'd2,
        FP_INF    = 3'd3,
        FP_NAN    = 3'd4
    } fp_class_t;

    function automatic int fp_bias(input int exp_width);
        return (32'sd1 <<< (exp_width - 32'sd1)) - 32'sd1;
    endfunction

    function automatic int fp_exp_all_ones(input int exp_width);
        return (32'sd1 <<< exp_width) - 32'sd1;
    endfunction

    function automatic int fp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational field decoder: classifies a packed float and yields its sign and unbiased
// exponent. Stateless so it can be shared with fp_adder checkers.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23
) (
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] fp_i,
    output fp_class_t                         class_o,
    output logic                              sign_o,
    output logic signed [EXP_WIDTH:0]         exp_unb_o
);

    localparam logic [EXP_WIDTH-1:0]   EXP_ONES = EXP_WIDTH'(fp_exp_all_ones(EXP_WIDTH));
    localparam logic signed [EXP_WIDTH:0] BIAS_S = (EXP_WIDTH+1)'(fp_bias(EXP_WIDTH));

    logic [EXP_WIDTH-1:0]      exp_f;
    logic [MANTISSA_WIDTH-1:0] mant_f;

    assign exp_f  = fp_i[EXP_WIDTH+MANTISSA_WIDTH-1 -: EXP_WIDTH];
    assign mant_f = fp_i[MANTISSA_WIDTH-1:0];
    assign sign_o = fp_i[EXP_WIDTH+MANTISSA_WIDTH];

    // Decode the class and remove the exponent bias (one extra bit keeps it signed).
    always_comb begin
        class_o   = FP_NORMAL;
        exp_unb_o = $signed({1'b0, exp_f}) - BIAS_S;
        if (exp_f == EXP_ONES) begin
            class_o = (mant_f == '0) ? FP_INF : FP_NAN;
        end else if (exp_f == '0) begin
            class_o = (mant_f == '0) ? FP_ZERO : FP_DENORM;
        end else begin
            class_o = FP_NORMAL;
        end
    end

endmodule

// File: rtl/fp_to_int_converter.sv
// Iterative float-to-signed-integer converter, truncating toward zero, with saturation
// and a start/ready/done handshake; the mantissa is aligned one bit per cycle.
module fp_to_int_converter
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int INT_WIDTH      = 32
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              start_in,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] fp_in,
    output logic                              ready_out,
    output logic                              done_out,
    output logic [INT_WIDTH-1:0]              int_out,
    output logic                              overflow_out,
    output logic                              underflow_out,
    output logic                              invalid_out
);

    localparam int FP_W      = EXP_WIDTH + MANTISSA_WIDTH + 1;
    localparam int ACC_W     = fp_max(INT_WIDTH, MANTISSA_WIDTH + 1);
    localparam int MAX_SHIFT = fp_max(MANTISSA_WIDTH, INT_WIDTH - 2 - MANTISSA_WIDTH);
    localparam int CNT_W     = $clog2(MAX_SHIFT + 1);

    localparam logic [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

    fti_state_t           state_q;
    logic [FP_W-1:0]      op_q;
    logic [ACC_W-1:0]     acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 left_q;
    logic                 ready_q;
    logic                 done_q;
    logic [INT_WIDTH-1:0] int_q;
    logic                 ovf_q;
    logic                 unf_q;
    logic                 inv_q;

    fp_class_t                cls_s;
    logic                     sign_s;
    logic signed [EXP_WIDTH:0] exp_unb_s;
    int                       e_s;
    logic                     mant_zero_s;

    fti_state_t           chk_state_d;
    logic [INT_WIDTH-1:0] chk_int_d;
    logic                 chk_ovf_d;
    logic                 chk_unf_d;
    logic                 chk_inv_d;
    logic [ACC_W-1:0]     chk_acc_d;
    logic                 chk_left_d;
    logic [CNT_W-1:0]     chk_cnt_d;

    fp_classify #(
        .EXP_WIDTH      (EXP_WIDTH),
        .MANTISSA_WIDTH (MANTISSA_WIDTH)
    ) u_classify (
        .fp_i      (op_q),
        .class_o   (cls_s),
        .sign_o    (sign_s),
        .exp_unb_o (exp_unb_s)
    );

    assign e_s         = int'(exp_unb_s);
    assign mant_zero_s = (op_q[MANTISSA_WIDTH-1:0] == '0);

    // CHECK-state decision: either a final special-case result or the shift setup.
    always_comb begin
        chk_state_d = DONE;
        chk_int_d   = '0;
        chk_ovf_d   = 1'b0;
        chk_unf_d   = 1'b0;
        chk_inv_d   = 1'b0;
        chk_acc_d   = ACC_W'({1'b1, op_q[MANTISSA_WIDTH-1:0]});
        chk_left_d  = 1'b0;
        chk_cnt_d   = '0;
        if (cls_s == FP_NAN) begin
            chk_inv_d = 1'b1;
            chk_int_d = INT_MAX;
        end else if (cls_s == FP_INF) begin
            chk_ovf_d = 1'b1;
            chk_int_d = sign_s ? INT_MIN : INT_MAX;
        end else if (cls_s == FP_ZERO) begin
            chk_int_d = '0;
        end else if (cls_s == FP_DENORM) begin
            chk_unf_d = 1'b1;
        end else if (e_s < 0) begin
            chk_unf_d = 1'b1;
        end else if ((e_s == INT_WIDTH - 1) && sign_s && mant_zero_s) begin
            chk_int_d = INT_MIN;
        end else if (e_s >= INT_WIDTH - 1) begin
            chk_ovf_d = 1'b1;
            chk_int_d = sign_s ? INT_MIN : INT_MAX;
        end else begin
            if (e_s > MANTISSA_WIDTH) begin
                chk_left_d = 1'b1;
                chk_cnt_d  = CNT_W'(e_s - MANTISSA_WIDTH);
            end else begin
                chk_left_d = 1'b0;
                chk_cnt_d  = CNT_W'(MANTISSA_WIDTH - e_s);
            end
            chk_state_d = (chk_cnt_d == '0) ? SIGN : SHIFT;
        end
    end

    // Conversion FSM with registered handshake and result outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            int_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        op_q    <= fp_in;
                        ready_q <= 1'b0;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    acc_q   <= chk_acc_d;
                    cnt_q   <= chk_cnt_d;
                    left_q  <= chk_left_d;
                    state_q <= chk_state_d;
                    if (chk_state_d == DONE) begin
                        int_q  <= chk_int_d;
                        ovf_q  <= chk_ovf_d;
                        unf_q  <= chk_unf_d;
                        inv_q  <= chk_inv_d;
                        done_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Right shifts drop LSBs, which is exactly truncation toward zero.
                    acc_q <= left_q ? {acc_q[ACC_W-2:0], 1'b0} : {1'b0, acc_q[ACC_W-1:1]};
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= SIGN;
                    end
                end
                SIGN: begin
                    int_q   <= sign_s ? (-acc_q[INT_WIDTH-1:0]) : acc_q[INT_WIDTH-1:0];
                    ovf_q   <= 1'b0;
                    unf_q   <= 1'b0;
                    inv_q   <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_out     = ready_q;
    assign done_out      = done_q;
    assign int_out       = int_q;
    assign overflow_out  = ovf_q;
    assign underflow_out = unf_q;
    assign invalid_out   = inv_q;

endmodule

// File: tb/tb_fp_to_int_converter.sv
// Self-checking bench for fp_to_int_converter: directed and random operands against an
// arithmetic reference model, plus busy-start and reset-abort sequences.
module tb_fp_to_int_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] fp;
    logic        ready;
    logic        done;
    logic [31:0] int_res;
    logic        ovf;
    logic        unf;
    logic        inv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_to_int_converter #(
        .EXP_WIDTH      (8),
        .MANTISSA_WIDTH (23),
        .INT_WIDTH      (32)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .start_in      (start),
        .fp_in         (fp),
        .ready_out     (ready),
        .done_out      (done),
        .int_out       (int_res),
        .overflow_out  (ovf),
        .underflow_out (unf),
        .invalid_out   (inv)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Reference: value = {1,mant} * 2**(e-23), truncated, then range-checked as a signed 64-bit number.
    function automatic void ref_model(input logic [31:0] f, output logic [31:0] val,
                                      output logic [2:0] flags, output int lat);
        logic   s;
        int     ex;
        int     e;
        longint m;
        longint sv;
        s     = f[31];
        ex    = int'(f[30:23]);
        m     = longint'({1'b1, f[22:0]});
        lat   = 2;
        flags = 3'b000;
        val   = 32'h0;
        if (ex == 255) begin
            if (f[22:0] != 23'h0) begin
                flags = 3'b001;
                val   = 32'h7FFFFFFF;
            end else begin
                flags = 3'b100;
                val   = s ? 32'h80000000 : 32'h7FFFFFFF;
            end
        end else if (ex == 0) begin
            flags = (f[22:0] != 23'h0) ? 3'b010 : 3'b000;
        end else begin
            e = ex - 127;
            if (e < 0) begin
                flags = 3'b010;
            end else if (e >= 40) begin
                flags = 3'b100;
                val   = s ? 32'h80000000 : 32'h7FFFFFFF;
            end else begin
                sv = (e >= 23) ? (m <<< (e - 23)) : (m >>> (23 - e));
                if (s) sv = -sv;
                if (sv > 64'sd2147483647 || sv < -64'sd2147483648) begin
                    flags = 3'b100;
                    val   = s ? 32'h80000000 : 32'h7FFFFFFF;
                end else begin
                    val = sv[31:0];
                end
                if (e <= 30) lat = 3 + ((e >= 23) ? (e - 23) : (23 - e));
            end
        end
    endfunction

    task automatic convert(input logic [31:0] f, input string tag);
        logic [31:0] ev;
        logic [2:0]  ef;
        int          el;
        int          n;
        ref_model(f, ev, ef, el);
        n = 0;
        while (!ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " ready"}, 32'(ready), 32'd1);
        @(negedge clk);
        start = 1'b1;
        fp    = f;
        @(posedge clk); #1;
        n = 1;
        while (!done && n < 60) begin
            @(negedge clk);
            start = 1'b0;
            fp    = $urandom();
            @(posedge clk); #1;
            n++;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(el));
        check({tag, " value"}, int_res, ev);
        check({tag, " flags"}, 32'({ovf, unf, inv}), 32'(ef));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, " pulse"}, 32'({done, ready}), 32'b01);
    endtask

    initial begin
        logic [31:0] dir_vec [14];
        int          n;
        int          bad;
        logic [31:0] rv;

        rst_n = 1'b0;
        start = 1'b0;
        fp    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", {int_res[31:0]}, 32'h0);
        check("reset ctrl", 32'({ready, done, ovf, unf, inv}), 32'b10000);
        @(negedge clk);
        rst_n = 1'b1;

        dir_vec = '{32'h40490FDB, 32'hC2F6E979, 32'h4B800001, 32'h3F800000,
                    32'h4F000000, 32'hCF000000, 32'hFF800000, 32'h3F000000,
                    32'h00000001, 32'h80000000, 32'h7FC00000, 32'h4EFFFFFF,
                    32'hCF000001, 32'h7F800000};
        for (int i = 0; i < 14; i++) begin
            convert(dir_vec[i], $sformatf("dir_%08h", dir_vec[i]));
        end

        // Busy: start held high with changing operands; only the first converts.
        @(negedge clk);
        start = 1'b1;
        fp    = 32'h40490FDB;
        @(posedge clk); #1;
        n   = 1;
        bad = 0;
        while (!done && n < 60) begin
            if (ready) bad++;
            @(negedge clk);
            fp = $urandom();
            @(posedge clk); #1;
            n++;
        end
        if (ready) bad++;
        check("busy ready low", 32'(bad), 32'd0);
        check("busy latency", 32'(n), 32'd25);
        check("busy value", int_res, 32'd3);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("busy pulse", 32'({done, ready}), 32'b01);

        // Reset during SHIFT aborts the conversion.
        @(negedge clk);
        start = 1'b1;
        fp    = 32'h40490FDB;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort ctrl", 32'({ready, done, ovf, unf, inv}), 32'b10000);
        check("abort int", int_res, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad   = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) bad++;
        end
        check("abort no done", 32'(bad), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rv[31]    = 1'($urandom_range(0, 1));
            rv[30:23] = (i % 4 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(120, 158));
            rv[22:0]  = 23'($urandom());
            convert(rv, $sformatf("rand%0d_%08h", i, rv));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
